overlay_scanout_reader: RTL and testbench

Avalon-MM read master plus Avalon-ST source that sits directly downstream of the 512K x 32 on-chip overlay memory. It scans a contiguous frame of 32-bit words out of that memory, starting at a programmable word address, buffers them in a small FIFO, and presents them as a packetised pixel stream with start/end-of-packet markers to the overlay compositor. It drives the memory's chipselect/address/write/byteenable and consumes its readdata with the memory's fixed one-cycle read latency.

---
 rtl/overlay_scanout_reader.sv | 136 +++++++++++++
 tb/tb_overlay_scanout_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_scanout_reader.sv
// Scans a frame of words out of the overlay memory into an 8-deep FIFO and streams them with sop/eop.
// First word reaches src_valid three cycles after start; reads are issued only against free FIFO credit.
module overlay_scanout_reader #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 32,
   parameter int CNT_W      = 20,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              loop,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  frame_words,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_chipselect,
   output logic              m_write,
   output logic [3:0]        m_byteenable,
   input  logic [DATA_W-1:0] m_readdata,
   output logic [DATA_W-1:0] src_data,
   output logic              src_valid,
   input  logic              src_ready,
   output logic              src_sop,
   output logic              src_eop,
   output logic              busy,
   output logic              frame_done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW+1:0] DEPTH_L = (PW+2)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]        state;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  len_q;
   logic [CNT_W-1:0]  issued;
   logic              rd_pend;
   logic              pend_sop;
   logic              pend_eop;

   logic [DATA_W+1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW:0]       fifo_count;
   logic [DATA_W+1:0] head;

   logic [PW+1:0]     credit_used;
   logic              issue;
   logic              last_issue;
   logic              pop;
   logic              eop_pop;

   // The read in flight still owns a FIFO slot until its data lands.
   assign credit_used = {1'b0, fifo_count} + {{(PW+1){1'b0}}, rd_pend};
   assign issue       = (state == S_FETCH) && (credit_used < DEPTH_L);
   assign last_issue  = (issued == (len_q - CNT_W'(1)));

   assign head      = fifo_mem[rd_ptr];
   assign src_valid = (fifo_count != '0);
   assign src_data  = src_valid ? head[DATA_W-1:0] : '0;
   assign src_sop   = src_valid & head[DATA_W];
   assign src_eop   = src_valid & head[DATA_W+1];
   assign pop       = src_valid & src_ready;
   assign eop_pop   = pop & src_eop;

   assign m_chipselect = issue;
   assign m_address    = issue ? (base_q + issued[ADDR_W-1:0]) : '0;
   assign m_write      = 1'b0;
   assign m_byteenable = 4'hF;
   assign busy         = (state != S_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         issued     <= '0;
         rd_pend    <= 1'b0;
         pend_sop   <= 1'b0;
         pend_eop   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= eop_pop;
         rd_pend    <= issue;
         pend_sop   <= issue && (issued == '0);
         pend_eop   <= issue && last_issue;
         case (state)
            S_IDLE: begin
               if (start && (frame_words != '0)) begin
                  base_q <= base_addr;
                  len_q  <= frame_words;
                  issued <= '0;
                  state  <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (issue) begin
                  issued <= issued + CNT_W'(1);
                  if (last_issue) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (eop_pop) begin
                  issued <= '0;
                  state  <= loop ? S_FETCH : S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rd_pend) fifo_mem[wr_ptr] <= {pend_eop, pend_sop, m_readdata};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (rd_pend) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         case ({rd_pend, pop})
            2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_overlay_scanout_reader.sv
// Bench for overlay_scanout_reader: memory model, stream scoreboard and address checker.
module tb_overlay_scanout_reader;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        loop = 1'b0;
   logic [18:0] base_addr = '0;
   logic [19:0] frame_words = '0;
   logic [18:0] m_address;
   logic        m_chipselect;
   logic        m_write;
   logic [3:0]  m_byteenable;
   logic [31:0] m_readdata = '0;
   logic [31:0] src_data;
   logic        src_valid;
   logic        src_ready = 1'b1;
   logic        src_sop;
   logic        src_eop;
   logic        busy;
   logic        frame_done;

   overlay_scanout_reader dut (
      .clk(clk), .reset_n(reset_n), .start(start), .loop(loop),
      .base_addr(base_addr), .frame_words(frame_words),
      .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
      .m_byteenable(m_byteenable), .m_readdata(m_readdata),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .src_sop(src_sop), .src_eop(src_eop), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // mem[i] = i, one-cycle read latency
   always @(posedge clk) if (m_chipselect && !m_write) m_readdata <= 32'(m_address);

   typedef struct {
      logic [31:0] d;
      logic        s;
      logic        e;
   } exp_t;

   typedef struct {
      logic [18:0] base;
      logic [19:0] len;
      int          rmode;
      int          sop_lat;
      int          eop_lat;
   } vec_t;

   exp_t        q[$];
   logic [18:0] aq[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ready_mode = 0;
   int start_cyc = 0;
   int first_valid_cyc = -1;
   int last_eop_cyc = 0;
   int done_cnt = 0;
   int hs_cnt = 0;
   int outs = 0;
   bit armed = 0;
   bit prev_stall = 0;
   logic [33:0] prev_word = '0;

   task automatic check(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      src_ready = (ready_mode == 0) || (cyc % 3 == 0);
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         prev_stall = 0;
         outs = 0;
      end else begin
         if (prev_stall)
            check("stall_hold", 64'({src_valid, src_eop, src_sop, src_data}), 64'({1'b1, prev_word}));
         if (m_chipselect) begin
            if (aq.size() == 0) check("unexpected_issue", 64'(m_address), 64'hFFFF_FFFF);
            else check("issue_addr", 64'(m_address), 64'(aq.pop_front()));
            check("write_be", 64'({m_write, m_byteenable}), 64'h0F);
            outs++;
         end
         if (src_valid && src_ready) begin
            exp_t x;
            outs--;
            hs_cnt++;
            if (q.size() == 0) check("unexpected_word", 64'(src_data), 64'hFFFF_FFFF);
            else begin
               x = q.pop_front();
               check("word", 64'({src_data, src_sop, src_eop}), 64'({x.d, x.s, x.e}));
            end
            if (src_eop) last_eop_cyc = cyc;
         end
         if (m_chipselect) check("outstanding_le_depth", 64'(outs <= 8), 64'd1);
         if (armed && src_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (frame_done) begin
            done_cnt++;
            check("done_after_eop", 64'(cyc), 64'(last_eop_cyc + 1));
         end
         prev_stall = src_valid && !src_ready;
         prev_word  = {src_eop, src_sop, src_data};
      end
   end

   task automatic push_frame(input logic [18:0] b, input logic [19:0] n);
      for (int i = 0; i < int'(n); i++) begin
         exp_t x;
         logic [18:0] a;
         a = b + 19'(i);
         x.d = 32'(a);
         x.s = (i == 0);
         x.e = (i == int'(n) - 1);
         q.push_back(x);
         aq.push_back(a);
      end
   endtask

   task automatic pulse_start(input logic [18:0] b, input logic [19:0] n);
      @(posedge clk); #1;
      base_addr = b;
      frame_words = n;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic launch(input logic [18:0] b, input logic [19:0] n, input int rmode);
      ready_mode = rmode;
      push_frame(b, n);
      @(posedge clk); #1;
      base_addr = b;
      frame_words = n;
      start = 1'b1;
      start_cyc = cyc;
      first_valid_cyc = -1;
      armed = 1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_cnt < target && n < 3000) begin
         @(posedge clk);
         n++;
      end
      check("frame_done_timeout", 64'(done_cnt >= target), 64'd1);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outs();
      check("rst_ctrl", 64'({m_chipselect, src_valid, src_sop, src_eop, busy, frame_done}), 64'd0);
      check("rst_addr", 64'(m_address), 64'd0);
      check("rst_data", 64'(src_data), 64'd0);
   endtask

   vec_t vecs[4];

   initial begin
      int d0;
      int e1;
      vecs[0] = '{base: 19'h00100, len: 20'd16, rmode: 0, sop_lat: 3, eop_lat: 18};
      vecs[1] = '{base: 19'h00200, len: 20'd32, rmode: 1, sop_lat: 3, eop_lat: 0};
      vecs[2] = '{base: 19'h7FFFE, len: 20'd4,  rmode: 0, sop_lat: 3, eop_lat: 6};
      vecs[3] = '{base: 19'h00050, len: 20'd1,  rmode: 0, sop_lat: 3, eop_lat: 3};

      repeat (3) @(negedge clk);
      check_reset_outs();
      @(posedge clk); #1;
      reset_n = 1'b1;
      wait_cycles(2);

      for (int v = 0; v < 4; v++) begin
         d0 = done_cnt;
         launch(vecs[v].base, vecs[v].len, vecs[v].rmode);
         wait_done(d0 + 1);
         check("sop_latency", 64'(first_valid_cyc - start_cyc), 64'(vecs[v].sop_lat));
         if (vecs[v].eop_lat != 0)
            check("eop_latency", 64'(last_eop_cyc - start_cyc), 64'(vecs[v].eop_lat));
         check("busy_after_done", 64'(busy), 64'd0);
         wait_cycles(3);
         check("done_once", 64'(done_cnt), 64'(d0 + 1));
         check("queue_empty", 64'(q.size() + aq.size()), 64'd0);
      end

      // zero-length start is ignored
      ready_mode = 0;
      pulse_start(19'h00400, 20'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("len0_idle", 64'({busy, m_chipselect}), 64'd0);
      end

      // loop mode, dropped during the second frame
      d0 = done_cnt;
      loop = 1'b1;
      launch(19'h00300, 20'd8, 0);
      push_frame(19'h00300, 20'd8);
      wait_done(d0 + 1);
      e1 = last_eop_cyc;
      wait_cycles(3);
      check("loop_busy", 64'(busy), 64'd1);
      loop = 1'b0;
      wait_done(d0 + 2);
      check("loop_restart_gap", 64'(last_eop_cyc - e1), 64'd10);
      wait_cycles(6);
      check("loop_end", 64'({busy, 32'(done_cnt - d0)}), 64'({1'b0, 32'd2}));
      check("loop_queue_empty", 64'(q.size() + aq.size()), 64'd0);

      // start while busy is ignored
      d0 = done_cnt;
      launch(19'h00400, 20'd16, 0);
      wait_cycles(2);
      pulse_start(19'h00900, 20'd5);
      wait_done(d0 + 1);
      wait_cycles(8);
      check("busy_start_ignored", 64'({busy, 32'(q.size() + aq.size())}), 64'd0);

      // reset mid-frame
      d0 = hs_cnt;
      launch(19'h00500, 20'd16, 0);
      for (int n = 0; n < 200 && hs_cnt < d0 + 5; n++) @(posedge clk);
      check("midframe_words_seen", 64'(hs_cnt >= d0 + 5), 64'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check_reset_outs();
      q.delete();
      aq.delete();
      armed = 0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      d0 = done_cnt;
      launch(19'h00600, 20'd6, 0);
      wait_done(d0 + 1);
      check("post_reset_sop_latency", 64'(first_valid_cyc - start_cyc), 64'd3);
      wait_cycles(3);
      check("post_reset_queue_empty", 64'(q.size() + aq.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
